// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - main-memory req/ack port of the cache refill controller
interface cache_refill_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss handler sequencing write-back and refill; optional CACHE_WB_BUFFER_EN
module cache_refill_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miss,
  input  logic [31:0] miss_addr,
  input  logic        memwr,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] refill_data,
  output logic        refill_valid,
  output logic        stall,
  output logic        err,
  cache_refill_ctrl_if.master mem
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
`ifdef CACHE_WB_BUFFER_EN
  localparam logic [2:0] ST_DRAIN = 3'd4;
`endif

  // Counter value at which an unacknowledged request is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [29:0] miss_addr_q, miss_addr_d;
  logic [29:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        pend_miss_q, pend_miss_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] refill_data_q, refill_data_d;
  logic        refill_valid_q, refill_valid_d;
  logic        err_q, err_d;
`ifdef CACHE_WB_BUFFER_EN
  logic        wb_pend_q, wb_pend_d;
  logic        drain_latch;
`endif

  logic ack;
  logic timed_out;
  logic done;

  // Memory addresses are word aligned, so the byte-offset bits are never stored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{miss_addr[1:0], wb_addr[1:0]};

  // An ack only counts while a request is actually outstanding.
  assign ack       = req_q & mem.mem_ack;
  assign timed_out = req_q & ~mem.mem_ack & (tmo_q == TMO_LAST);
  assign done      = ack | timed_out;

  // Next-state logic: request issue/complete, timeout and stray-input errors.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    miss_addr_d    = miss_addr_q;
    wb_addr_d      = wb_addr_q;
    wb_data_d      = wb_data_q;
    pend_miss_d    = pend_miss_q;
    tmo_d          = tmo_q;
    refill_data_d  = refill_data_q;
    refill_valid_d = 1'b0;
    err_d          = err_q;
`ifdef CACHE_WB_BUFFER_EN
    wb_pend_d      = wb_pend_q;
    drain_latch    = 1'b0;
`endif

    if (req_q) begin
      if (done) req_d = 1'b0;
      else      tmo_d = tmo_q + 8'd1;
    end
    if (timed_out) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (memwr) begin
          wb_addr_d = wb_addr[31:2];
          wb_data_d = wb_data;
        end
        if (miss) miss_addr_d = miss_addr[31:2];
`ifdef CACHE_WB_BUFFER_EN
        // Read first; a coinciding victim waits in the buffer until after the fill.
        if (miss) begin
          state_d   = ST_READ;
          wb_pend_d = memwr;
        end else if (memwr) begin
          state_d     = ST_WRITE;
          pend_miss_d = 1'b0;
        end
`else
        if (memwr) begin
          state_d     = ST_WRITE;
          pend_miss_d = miss;
        end else if (miss) begin
          state_d = ST_READ;
        end
`endif
      end

      ST_WRITE: begin
        if (miss | memwr) err_d = 1'b1;
        if (!req_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {wb_addr_q, 2'b00};
          wdata_d = wb_data_q;
          tmo_d   = 8'd0;
        end else if (done) begin
          state_d     = pend_miss_q ? ST_READ : ST_IDLE;
          pend_miss_d = 1'b0;
        end
      end

      ST_READ: begin
        if (miss | memwr) err_d = 1'b1;
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = {miss_addr_q, 2'b00};
          tmo_d  = 8'd0;
        end else if (done) begin
          refill_data_d = ack ? mem.mem_rdata : 32'h0;
          state_d       = ST_FILL;
        end
      end

      ST_FILL: begin
        if (miss | memwr) err_d = 1'b1;
        if (!refill_valid_q) begin
          refill_valid_d = 1'b1;
        end else begin
`ifdef CACHE_WB_BUFFER_EN
          state_d = wb_pend_q ? ST_DRAIN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end

`ifdef CACHE_WB_BUFFER_EN
      ST_DRAIN: begin
        if (memwr) err_d = 1'b1;
        if (miss) begin
          if (pend_miss_q) begin
            err_d = 1'b1;
          end else if (miss_addr[31:2] == wb_addr_q) begin
            // Hit on the buffered victim: serve it without a memory read.
            refill_data_d  = wb_data_q;
            refill_valid_d = 1'b1;
          end else begin
            miss_addr_d = miss_addr[31:2];
            pend_miss_d = 1'b1;
            drain_latch = 1'b1;
          end
        end
        if (!req_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {wb_addr_q, 2'b00};
          wdata_d = wb_data_q;
          tmo_d   = 8'd0;
        end else if (done) begin
          wb_pend_d   = 1'b0;
          state_d     = (pend_miss_q | drain_latch) ? ST_READ : ST_IDLE;
          pend_miss_d = 1'b0;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      miss_addr_q    <= 30'h0;
      wb_addr_q      <= 30'h0;
      wb_data_q      <= 32'h0;
      pend_miss_q    <= 1'b0;
      tmo_q          <= 8'h0;
      refill_data_q  <= 32'h0;
      refill_valid_q <= 1'b0;
      err_q          <= 1'b0;
`ifdef CACHE_WB_BUFFER_EN
      wb_pend_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      miss_addr_q    <= miss_addr_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      pend_miss_q    <= pend_miss_d;
      tmo_q          <= tmo_d;
      refill_data_q  <= refill_data_d;
      refill_valid_q <= refill_valid_d;
      err_q          <= err_d;
`ifdef CACHE_WB_BUFFER_EN
      wb_pend_q      <= wb_pend_d;
`endif
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign refill_data   = refill_data_q;
  assign refill_valid  = refill_valid_q;
  assign err           = err_q;
`ifdef CACHE_WB_BUFFER_EN
  // While draining the buffered write the pipeline runs unless a miss is waiting.
  assign stall = (state_q != ST_IDLE) && !((state_q == ST_DRAIN) && !pend_miss_q);
`else
  assign stall = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - scoreboard bench for cache_refill_ctrl
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] miss_addr = 32'h0;
  logic        memwr = 1'b0;
  logic [31:0] wb_addr = 32'h0;
  logic [31:0] wb_data = 32'h0;
  logic [31:0] refill_data;
  logic        refill_valid;
  logic        stall;
  logic        err;

  cache_refill_ctrl_if mif();

  cache_refill_ctrl #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .miss         (miss),
    .miss_addr    (miss_addr),
    .memwr        (memwr),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .refill_data  (refill_data),
    .refill_valid (refill_valid),
    .stall        (stall),
    .err          (err),
    .mem          (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_fill[$];

  int n_vec = 0;
  int n_err = 0;
  int stall_cyc = 0;
  int req_hi = 0;
  int fill_cnt = 0;

  bit          ack_en = 1'b1;
  int          ack_delay = 3;
  logic [31:0] rdata_cfg = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // Memory model: ack ack_delay cycles after the request rises.
  initial begin
    int cnt;
    cnt = 0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        cnt++;
        if (ack_en && cnt == ack_delay) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = rdata_cfg;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares every new request and every refill strobe against the scoreboard.
  initial begin
    logic req_prev;
    req_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.mem_req && !req_prev) begin
        if (exp_req.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: got we=%0b addr=0x%08h expected none", mif.mem_we, mif.mem_addr);
        end else begin
          e = exp_req.pop_front();
          check("req_we", {31'h0, mif.mem_we}, {31'h0, e.we});
          check("req_addr", mif.mem_addr, e.addr);
          if (e.we) check("req_wdata", mif.mem_wdata, e.wdata);
        end
      end
      req_prev = mif.mem_req;
      if (mif.mem_req) req_hi++;
      if (stall) stall_cyc++;
      if (refill_valid) begin
        fill_cnt++;
        if (exp_fill.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_fill: got 0x%08h expected none", refill_data);
        end else begin
          check("refill_data", refill_data, exp_fill.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic m, input logic [31:0] ma, input logic w,
                       input logic [31:0] wa, input logic [31:0] wd);
    @(negedge clk);
    miss = m; miss_addr = ma; memwr = w; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    miss = 1'b0; memwr = 1'b0;
  endtask

  task automatic wait_quiet();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      @(negedge clk);
      if (!stall && !mif.mem_req && !refill_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_vec++; n_err++;
      $display("FAIL wait_quiet: got busy after 300 cycles expected idle");
    end
  endtask

  task automatic wait_req(input logic need_we);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mif.mem_req && (mif.mem_we == need_we)) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: got no request expected we=%0b", need_we);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'h0, mif.mem_req}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_refill_valid", {31'h0, refill_valid}, 32'h0);
    check("rst_refill_data", refill_data, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Clean miss, ack after 3 cycles
    ack_en = 1'b1; ack_delay = 3; rdata_cfg = 32'hCAFE_F00D;
    exp_req.push_back(mk(1'b0, 32'h0000_0104, 32'h0));
    exp_fill.push_back(32'hCAFE_F00D);
    stall_cyc = 0; fill_cnt = 0;
    issue(1'b1, 32'h0000_0104, 1'b0, 32'h0, 32'h0);
    wait_quiet();
    check("clean_stall_cycles", stall_cyc, 32'd6);
    check("clean_fill_count", fill_cnt, 32'd1);
    check("clean_err", {31'h0, err}, 32'h0);

    // Dirty miss
    ack_delay = 2; rdata_cfg = 32'h55AA_0040;
    fill_cnt = 0;
`ifdef CACHE_WB_BUFFER_EN
    exp_req.push_back(mk(1'b0, 32'h0000_0040, 32'h0));
    exp_fill.push_back(32'h55AA_0040);
    exp_req.push_back(mk(1'b1, 32'h0000_0020, 32'h1234_5678));
    ack_delay = 6;
    issue(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0020, 32'h1234_5678);
    wait_req(1'b1);
    check("drain_stall", {31'h0, stall}, 32'h0);
    exp_fill.push_back(32'h1234_5678);
    issue(1'b1, 32'h0000_0020, 1'b0, 32'h0, 32'h0);
    wait_quiet();
    check("dirty_fill_count", fill_cnt, 32'd2);
`else
    exp_req.push_back(mk(1'b1, 32'h0000_0020, 32'h1234_5678));
    exp_req.push_back(mk(1'b0, 32'h0000_0040, 32'h0));
    exp_fill.push_back(32'h55AA_0040);
    issue(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0020, 32'h1234_5678);
    wait_quiet();
    check("dirty_fill_count", fill_cnt, 32'd1);
`endif
    check("dirty_err", {31'h0, err}, 32'h0);

    // Timeout with ack held low; byte address is word-aligned on the bus
    ack_en = 1'b0;
    exp_req.push_back(mk(1'b0, 32'h0000_0080, 32'h0));
    exp_fill.push_back(32'h0);
    req_hi = 0; fill_cnt = 0;
    issue(1'b1, 32'h0000_0083, 1'b0, 32'h0, 32'h0);
    wait_quiet();
    check("tmo_req_cycles", req_hi, 32'd8);
    check("tmo_fill_count", fill_cnt, 32'd1);
    check("tmo_err", {31'h0, err}, 32'h1);

    // err stays set through a later clean transaction
    ack_en = 1'b1; ack_delay = 1; rdata_cfg = 32'h0000_0200;
    exp_req.push_back(mk(1'b0, 32'h0000_0200, 32'h0));
    exp_fill.push_back(32'h0000_0200);
    issue(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h0);
    wait_quiet();
    check("err_sticky", {31'h0, err}, 32'h1);

    // Reset mid-READ
    ack_en = 1'b0; fill_cnt = 0;
    exp_req.push_back(mk(1'b0, 32'h0000_0500, 32'h0));
    issue(1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h0);
    wait_req(1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_req", {31'h0, mif.mem_req}, 32'h0);
    check("arst_stall", {31'h0, stall}, 32'h0);
    check("arst_refill_valid", {31'h0, refill_valid}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_err_cleared", {31'h0, err}, 32'h0);
    check("arst_idle", {31'h0, stall}, 32'h0);
    check("arst_no_fill", fill_cnt, 32'd0);

    // Miss during READ is dropped and flags err
    ack_en = 1'b1; ack_delay = 4; rdata_cfg = 32'hDEAD_0300;
    exp_req.push_back(mk(1'b0, 32'h0000_0300, 32'h0));
    exp_fill.push_back(32'hDEAD_0300);
    fill_cnt = 0;
    issue(1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h0);
    wait_req(1'b0);
    issue(1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h0);
    wait_quiet();
    check("stray_miss_err", {31'h0, err}, 32'h1);
    check("stray_fill_count", fill_cnt, 32'd1);

    check("exp_req_left", exp_req.size(), 32'd0);
    check("exp_fill_left", exp_fill.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
